// File: rtl/button_scan_ctrl.sv
// Shared debounce/auto-repeat scanner. One tick prescaler and one sample/count
// datapath are time-multiplexed across N_BTN synchronized button inputs.
module button_scan_ctrl #(
    parameter int unsigned N_BTN        = 4,
    parameter int unsigned TICK_DIV     = 100000,
    parameter int unsigned STABLE       = 7,
    parameter int unsigned REPEAT_DELAY = 250,
    parameter int unsigned REPEAT_RATE  = 50
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] button,
    output logic [N_BTN-1:0] level,
    output logic [N_BTN-1:0] press,
    output logic             tick,
    output logic             busy
);

    localparam int unsigned DivW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned IdxW = (N_BTN > 1) ? $clog2(N_BTN) : 1;
    localparam int unsigned CntW = (STABLE > 1) ? $clog2(STABLE + 1) : 1;

    typedef enum logic [0:0] {StIdle, StScan} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [DivW-1:0]   div_q, div_d;
    logic [N_BTN-1:0]  sync_meta_q, sync_q;
    logic [CntW-1:0]   cnt_q [N_BTN];
    logic [CntW-1:0]   cnt_d [N_BTN];
    logic [7:0]        rc_q  [N_BTN];
    logic [7:0]        rc_d  [N_BTN];
    logic [N_BTN-1:0]  level_q, level_d;
    logic [N_BTN-1:0]  press_q, press_d;

    assign tick  = (div_q == DivW'(TICK_DIV - 1));
    assign busy  = (state_q == StScan);
    assign level = level_q;
    assign press = press_q;

    // Two-flop synchronizer on the raw asynchronous buttons.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta_q <= '0;
            sync_q      <= '0;
        end else begin
            sync_meta_q <= button;
            sync_q      <= sync_meta_q;
        end
    end

    // Prescaler next-state: wraps at TICK_DIV-1.
    always_comb begin
        div_d = tick ? '0 : div_q + DivW'(1);
    end

    // Scan FSM next-state: one channel per clock after each tick.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (tick) begin
                    state_d = StScan;
                    idx_d   = '0;
                end
            end
            StScan: begin
                if (idx_q == IdxW'(N_BTN - 1)) begin
                    state_d = StIdle;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                idx_d   = '0;
            end
        endcase
    end

    // Per-channel debounce and repeat update for the channel under scan only.
    always_comb begin
        level_d = level_q;
        press_d = '0;
        for (int i = 0; i < N_BTN; i++) begin
            cnt_d[i] = cnt_q[i];
            rc_d[i]  = rc_q[i];
            if (busy && (idx_q == IdxW'(i))) begin
                if (!sync_q[i]) begin
                    cnt_d[i]   = '0;
                    rc_d[i]    = '0;
                    level_d[i] = 1'b0;
                end else if (cnt_q[i] < CntW'(STABLE)) begin
                    cnt_d[i] = cnt_q[i] + CntW'(1);
                end else if (!level_q[i]) begin
                    level_d[i] = 1'b1;
                    press_d[i] = 1'b1;
                    rc_d[i]    = 8'(REPEAT_DELAY);
                end else if (rc_q[i] == 8'd1) begin
                    press_d[i] = 1'b1;
                    rc_d[i]    = 8'(REPEAT_RATE);
                end else if (rc_q[i] != 8'd0) begin
                    rc_d[i] = rc_q[i] - 8'd1;
                end
            end
        end
    end

    // Registered state: prescaler, FSM, per-channel counters and outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q   <= '0;
            state_q <= StIdle;
            idx_q   <= '0;
            level_q <= '0;
            press_q <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= '0;
                rc_q[i]  <= '0;
            end
        end else begin
            div_q   <= div_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            level_q <= level_d;
            press_q <= press_d;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= cnt_d[i];
                rc_q[i]  <= rc_d[i];
            end
        end
    end

endmodule

// File: tb/tb_button_scan_ctrl.sv
// Directed bench for button_scan_ctrl with TICK_DIV=10, STABLE=7,
// REPEAT_DELAY=20, REPEAT_RATE=5. Cycle 0 is the first cycle with rst low.
module tb_button_scan_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] button;
    logic [3:0] level;
    logic [3:0] press;
    logic       tick;
    logic       busy;

    int cyc;
    int n_checks;
    int n_errors;

    button_scan_ctrl #(
        .N_BTN       (4),
        .TICK_DIV    (10),
        .STABLE      (7),
        .REPEAT_DELAY(20),
        .REPEAT_RATE (5)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .button(button),
        .level (level),
        .press (press),
        .tick  (tick),
        .busy  (busy)
    );

    // 10-unit clock period.
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Outputs for the current cycle; tick/busy follow the fixed tick schedule.
    task automatic check_cycle(input string tag, input logic [3:0] exp_l, input logic [3:0] exp_p);
        logic exp_t;
        logic exp_b;
        exp_t = (cyc % 10 == 9);
        exp_b = (cyc >= 10) && (cyc % 10 <= 3);
        check({tag, ".level"}, 32'(level), 32'(exp_l));
        check({tag, ".press"}, 32'(press), 32'(exp_p));
        check({tag, ".tick"},  32'(tick),  32'(exp_t));
        check({tag, ".busy"},  32'(busy),  32'(exp_b));
    endtask

    // Holds rst for n edges, checking outputs are cleared, then releases it.
    task automatic apply_reset(input int n);
        rst = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            check("rst.level", 32'(level), 32'd0);
            check("rst.press", 32'(press), 32'd0);
            check("rst.tick",  32'(tick),  32'd0);
            check("rst.busy",  32'(busy),  32'd0);
        end
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        logic [3:0] exp_l;
        logic [3:0] exp_p;
        int         n_p1;

        clk      = 1'b0;
        rst      = 1'b1;
        button   = 4'b0000;
        cyc      = 0;
        n_checks = 0;
        n_errors = 0;

        // Reset values and tick/busy schedule with no buttons pressed.
        apply_reset(3);
        while (cyc <= 25) begin
            check_cycle("idle", 4'b0000, 4'b0000);
            step();
        end

        // Clean press on channel 0, auto-repeat, then release.
        apply_reset(3);
        button = 4'b0001;
        while (cyc <= 500) begin
            exp_p = (cyc == 81 || cyc == 281 || cyc == 331 || cyc == 381) ? 4'b0001 : 4'b0000;
            exp_l = (cyc >= 81 && cyc < 411) ? 4'b0001 : 4'b0000;
            check_cycle("repeat", exp_l, exp_p);
            if (cyc == 400) button = 4'b0000;
            step();
        end

        // Bounce on channel 1: low during cycles 42..56, straddling the 5th tick.
        apply_reset(3);
        button = 4'b0010;
        n_p1   = 0;
        while (cyc <= 200) begin
            exp_p = (cyc == 132) ? 4'b0010 : 4'b0000;
            exp_l = (cyc >= 132) ? 4'b0010 : 4'b0000;
            check_cycle("bounce", exp_l, exp_p);
            n_p1 += int'(press[1]);
            if (cyc == 42) button = 4'b0000;
            if (cyc == 57) button = 4'b0010;
            step();
        end
        check("bounce.press_count", 32'(n_p1), 32'd1);

        // Simultaneous press: staggered one-hot pulses in channel order.
        apply_reset(3);
        button = 4'b1111;
        while (cyc <= 90) begin
            exp_p = (cyc >= 81 && cyc <= 84) ? (4'b0001 << (cyc - 81)) : 4'b0000;
            for (int i = 0; i < 4; i++) exp_l[i] = (cyc >= 81 + i);
            check_cycle("simul", exp_l, exp_p);
            step();
        end

        // Reset in cycle 12 while scanning with all buttons held.
        apply_reset(3);
        button = 4'b1111;
        while (cyc <= 12) begin
            check_cycle("premid", 4'b0000, 4'b0000);
            if (cyc == 12) break;
            step();
        end
        apply_reset(2);
        while (cyc <= 90) begin
            exp_p = (cyc >= 81 && cyc <= 84) ? (4'b0001 << (cyc - 81)) : 4'b0000;
            for (int i = 0; i < 4; i++) exp_l[i] = (cyc >= 81 + i);
            check_cycle("midrst", exp_l, exp_p);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
